branch_predictor_btb: RTL and testbench

- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters. It replaces the pipeline's fixed predict-not-taken fetch policy.
- Fetch stage: a combinational lookup on the fetch PC gives the predicted next PC.
- Execute stage: the resolved branch/jump updates the table, and the block reports misprediction plus the redirect PC that drives flush.
- Also keeps saturating performance counters for branches and mispredicts.

---
 rtl/branch_predictor_btb.sv | 129 ++++++++++++
 tb/tb_branch_predictor_btb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped BTB with saturating direction counters
// Fetch lookup is combinational; execute-stage resolution updates the table at the clock edge.
module branch_predictor_btb #(
  parameter int ENTRIES    = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int CTR_BITS   = 2,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] pc_f,
  output logic                  pred_taken_f,
  output logic [ADDR_WIDTH-1:0] pred_target_f,
  input  logic                  upd_valid_e,
  input  logic [ADDR_WIDTH-1:0] upd_pc_e,
  input  logic                  upd_taken_e,
  input  logic [ADDR_WIDTH-1:0] upd_target_e,
  input  logic                  upd_is_jump_e,
  input  logic                  upd_pred_taken_e,
  input  logic [ADDR_WIDTH-1:0] upd_pred_target_e,
  input  logic                  invalidate,
  output logic                  mispredict_e,
  output logic [ADDR_WIDTH-1:0] redirect_pc_e,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
    $error("branch_predictor_btb: ENTRIES must be a power of two >= 2");
  end
  if (CTR_BITS < 2) begin : g_bad_ctr
    $error("branch_predictor_btb: CTR_BITS must be >= 2");
  end

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_d    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_d [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_d    [ENTRIES];
  logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0]  mispredict_count_q, mispredict_count_d;

  logic [IDX-1:0]   idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             hit_f, hit_e;
  logic             unused_pc_lsbs;

  assign idx_f = pc_f[IDX+1:2];
  assign tag_f = pc_f[ADDR_WIDTH-1:IDX+2];
  assign idx_e = upd_pc_e[IDX+1:2];
  assign tag_e = upd_pc_e[ADDR_WIDTH-1:IDX+2];
  assign unused_pc_lsbs = ^{pc_f[1:0], upd_pc_e[1:0]};

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_taken_f  = hit_f && ctr_q[idx_f][CTR_BITS-1];
  assign pred_target_f = pred_taken_f ? target_q[idx_f] : pc_f + ADDR_WIDTH'(4);

  assign hit_e         = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign mispredict_e  = upd_valid_e &&
                         ((upd_pred_taken_e != upd_taken_e) ||
                          (upd_taken_e && (upd_pred_target_e != upd_target_e)));
  assign redirect_pc_e = upd_taken_e ? upd_target_e : upd_pc_e + ADDR_WIDTH'(4);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_valid_e) begin
      if (hit_e) begin
        if (upd_is_jump_e) begin
          ctr_d[idx_e]    = CTR_MAX;
          target_d[idx_e] = upd_target_e;
        end else if (upd_taken_e) begin
          if (ctr_q[idx_e] != CTR_MAX) ctr_d[idx_e] = ctr_q[idx_e] + CTR_BITS'(1);
          target_d[idx_e] = upd_target_e;
        end else if (ctr_q[idx_e] != '0) begin
          ctr_d[idx_e] = ctr_q[idx_e] - CTR_BITS'(1);
        end
      end else if (upd_taken_e) begin
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = upd_target_e;
        ctr_d[idx_e]    = upd_is_jump_e ? CTR_MAX : CTR_WEAK;
      end
    end
    if (invalidate) valid_d = '0;
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (upd_valid_e && (branch_count_q != '1))
      branch_count_d = branch_count_q + CNT_WIDTH'(1);
    if (mispredict_e && (mispredict_count_q != '1))
      mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q            <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Payload fields are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - directed self-checking bench for branch_predictor_btb
// Inputs change 1 time unit after posedge; outputs are checked 1 unit later.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        upd_valid_e;
  logic [31:0] upd_pc_e;
  logic        upd_taken_e;
  logic [31:0] upd_target_e;
  logic        upd_is_jump_e;
  logic        upd_pred_taken_e;
  logic [31:0] upd_pred_target_e;
  logic        invalidate;
  logic        mispredict_e;
  logic [31:0] redirect_pc_e;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  branch_predictor_btb dut (
    .clk               (clk),
    .rst               (rst),
    .pc_f              (pc_f),
    .pred_taken_f      (pred_taken_f),
    .pred_target_f     (pred_target_f),
    .upd_valid_e       (upd_valid_e),
    .upd_pc_e          (upd_pc_e),
    .upd_taken_e       (upd_taken_e),
    .upd_target_e      (upd_target_e),
    .upd_is_jump_e     (upd_is_jump_e),
    .upd_pred_taken_e  (upd_pred_taken_e),
    .upd_pred_target_e (upd_pred_target_e),
    .invalidate        (invalidate),
    .mispredict_e      (mispredict_e),
    .redirect_pc_e     (redirect_pc_e),
    .branch_count      (branch_count),
    .mispredict_count  (mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic v, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic jmp,
                     input logic ptk, input logic [31:0] ptgt);
    upd_valid_e       = v;
    upd_pc_e          = pc;
    upd_taken_e       = tk;
    upd_target_e      = tgt;
    upd_is_jump_e     = jmp;
    upd_pred_taken_e  = ptk;
    upd_pred_target_e = ptgt;
    #1;
  endtask

  task automatic idle();
    upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tgt);
    pc_f = pc;
    #1;
    check({tag, "_taken"}, 32'(pred_taken_f), 32'(tk));
    check({tag, "_target"}, pred_target_f, tgt);
  endtask

  task automatic counts(input string tag, input logic [31:0] b, input logic [31:0] m);
    check({tag, "_bcnt"}, branch_count, b);
    check({tag, "_mcnt"}, mispredict_count, m);
  endtask

  initial begin
    rst = 1'b1;
    invalidate = 1'b0;
    pc_f = 32'h100;
    upd_valid_e = 1'b0; upd_pc_e = '0; upd_taken_e = 1'b0; upd_target_e = '0;
    upd_is_jump_e = 1'b0; upd_pred_taken_e = 1'b0; upd_pred_target_e = '0;
    #2;
    look("reset", 32'h100, 1'b0, 32'h104);
    counts("reset", 0, 0);
    tick(); tick();
    rst = 1'b0;

    // First taken branch allocates weakly-taken
    tick();
    upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
    check("alloc_misp", 32'(mispredict_e), 1);
    check("alloc_redir", redirect_pc_e, 32'h80);
    look("alloc_pre", 32'h100, 1'b0, 32'h104);
    tick(); idle();
    counts("alloc", 1, 1);
    look("alloc_post", 32'h100, 1'b1, 32'h80);

    // Not-taken decrements; concurrent lookup sees old counter
    upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 1'b0, 32'h104);
    check("nt1_misp", 32'(mispredict_e), 0);
    check("nt1_redir", redirect_pc_e, 32'h104);
    look("nt1_same_cycle", 32'h100, 1'b1, 32'h80);
    tick(); idle();
    look("nt1_post", 32'h100, 1'b0, 32'h104);
    upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 1'b0, 32'h104);
    tick();
    upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 1'b0, 32'h104);
    tick(); idle();
    counts("nt3", 4, 1);
    // ctr must be 0: one taken update leaves it not-taken, second makes it taken
    upd(1'b1, 32'h100, 1'b1, 32'h88, 1'b0, 1'b0, 32'h104);
    tick(); idle();
    look("sat_low_1", 32'h100, 1'b0, 32'h104);
    upd(1'b1, 32'h100, 1'b1, 32'h88, 1'b0, 1'b0, 32'h104);
    tick(); idle();
    look("sat_low_2", 32'h100, 1'b1, 32'h88);
    counts("sat_low", 6, 3);

    // Aliasing on index 0
    look("alias_miss", 32'h140, 1'b0, 32'h144);
    upd(1'b1, 32'h140, 1'b1, 32'h200, 1'b0, 1'b0, 32'h144);
    tick(); idle();
    look("alias_new", 32'h140, 1'b1, 32'h200);
    look("alias_old", 32'h100, 1'b0, 32'h104);
    upd(1'b1, 32'h180, 1'b0, 32'h0, 1'b0, 1'b0, 32'h184);
    check("miss_nt_misp", 32'(mispredict_e), 0);
    tick(); idle();
    look("miss_nt_keep", 32'h140, 1'b1, 32'h200);
    look("miss_nt_noalloc", 32'h180, 1'b0, 32'h184);
    counts("alias", 8, 4);

    // Jump allocates strongly taken; wrong target corrects it
    upd(1'b1, 32'h20, 1'b1, 32'h300, 1'b1, 1'b0, 32'h24);
    tick(); idle();
    look("jump", 32'h20, 1'b1, 32'h300);
    upd(1'b1, 32'h20, 1'b1, 32'h310, 1'b1, 1'b1, 32'h300);
    check("wrongtgt_misp", 32'(mispredict_e), 1);
    check("wrongtgt_redir", redirect_pc_e, 32'h310);
    tick(); idle();
    look("wrongtgt_post", 32'h20, 1'b1, 32'h310);
    upd(1'b1, 32'h20, 1'b1, 32'h310, 1'b1, 1'b1, 32'h310);
    check("righttgt_misp", 32'(mispredict_e), 0);
    tick();
    // Taken branch at saturated counter stays taken; one not-taken leaves it taken
    upd(1'b1, 32'h20, 1'b1, 32'h310, 1'b0, 1'b1, 32'h310);
    tick(); idle();
    look("sat_high", 32'h20, 1'b1, 32'h310);
    upd(1'b1, 32'h20, 1'b0, 32'h310, 1'b0, 1'b1, 32'h310);
    check("nt_after_sat_misp", 32'(mispredict_e), 1);
    check("nt_after_sat_redir", redirect_pc_e, 32'h24);
    tick(); idle();
    look("nt_after_sat", 32'h20, 1'b1, 32'h310);
    counts("jump", 13, 7);

    // No update: mispredict forced low, redirect still computed
    upd(1'b0, 32'h50, 1'b0, 32'h900, 1'b0, 1'b1, 32'h900);
    check("novalid_misp", 32'(mispredict_e), 0);
    check("novalid_redir", redirect_pc_e, 32'h54);
    tick(); idle();
    counts("novalid", 13, 7);

    // Invalidate overrides same-cycle allocation but counters still count
    invalidate = 1'b1;
    upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
    tick(); idle();
    invalidate = 1'b0;
    look("inv_100", 32'h100, 1'b0, 32'h104);
    look("inv_20", 32'h20, 1'b0, 32'h24);
    look("inv_140", 32'h140, 1'b0, 32'h144);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    counts("inv", 14, 8);

    // Asynchronous reset mid-update, checked before any clock edge
    upd(1'b1, 32'h20, 1'b1, 32'h300, 1'b1, 1'b0, 32'h24);
    tick(); idle();
    look("repop", 32'h20, 1'b1, 32'h300);
    upd(1'b1, 32'h20, 1'b1, 32'h300, 1'b1, 1'b1, 32'h300);
    rst = 1'b1;
    #1;
    look("async_rst", 32'h20, 1'b0, 32'h24);
    counts("async_rst", 0, 0);
    tick(); idle();
    rst = 1'b0;
    tick();
    look("after_rst", 32'h20, 1'b0, 32'h24);
    counts("after_rst", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
